// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared byte/beat sizing helpers for stream width converters
package common_pkg;

  // Number of out_byts-wide beats needed to carry m valid bytes (ceil(m/out_byts)).
  function automatic int width_down_beats(input int m, input int out_byts);
    return (m + out_byts - 1) / out_byts;
  endfunction

  // Valid bytes in the final beat of an m-byte word; 0 encodes a full beat.
  function automatic int width_down_last_mod(input int m, input int out_byts);
    int rem;
    rem = m - (width_down_beats(m, out_byts) - 1) * out_byts;
    return (rem == out_byts) ? 0 : rem;
  endfunction

endpackage

// File: rtl/if_axi_stream.sv
// rtl/if_axi_stream.sv - packet stream link with sop/eop/mod/err/ctl framing
// Signals:
//   val/rdy  handshake (transfer when both high)
//   sop/eop  first/last beat of a packet
//   mod      valid bytes in an eop beat, 0 meaning all DAT_BYTS bytes
//   err      packet error, meaningful on the eop beat
//   dat/ctl  payload and sideband, byte 0 in dat[7:0]
interface if_axi_stream #(
  parameter int DAT_BYTS = 8,
  parameter int CTL_BYTS = 1
) ();
  localparam int DAT_BITS = DAT_BYTS * 8;
  localparam int CTL_BITS = CTL_BYTS * 8;
  localparam int MOD_BITS = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1;

  logic                val;
  logic                rdy;
  logic                sop;
  logic                eop;
  logic                err;
  logic [DAT_BITS-1:0] dat;
  logic [MOD_BITS-1:0] mod;
  logic [CTL_BITS-1:0] ctl;

  modport sink   (input  val, sop, eop, err, dat, mod, ctl, output rdy);
  modport source (output val, sop, eop, err, dat, mod, ctl, input  rdy);
endinterface

// File: rtl/axi_stream_width_down.sv
// rtl/axi_stream_width_down.sv - splits wide stream words into narrow beats, lowest byte first
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   i_axi    wide input stream  (IN_DAT_BYTS data bytes, CTL_BYTS ctl bytes)
//   o_axi    narrow output stream (OUT_DAT_BYTS data bytes, CTL_BYTS ctl bytes)
module axi_stream_width_down
  import common_pkg::*;
#(
  parameter int IN_DAT_BYTS  = 8,
  parameter int OUT_DAT_BYTS = 2,
  parameter int CTL_BYTS     = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  if_axi_stream.sink   i_axi,
  if_axi_stream.source o_axi
);

  localparam int R            = IN_DAT_BYTS / OUT_DAT_BYTS;
  localparam int OUT_DAT_BITS = OUT_DAT_BYTS * 8;
  localparam int CTL_BITS     = CTL_BYTS * 8;
  localparam int OUT_MOD_BITS = (OUT_DAT_BYTS > 1) ? $clog2(OUT_DAT_BYTS) : 1;
  localparam int K_BITS       = (R > 1) ? $clog2(R) : 1;

  if ((IN_DAT_BYTS % OUT_DAT_BYTS) != 0 || IN_DAT_BYTS <= OUT_DAT_BYTS) begin : g_bad_cfg
    $fatal(1, "axi_stream_width_down: IN_DAT_BYTS must be a larger integer multiple of OUT_DAT_BYTS");
  end

  typedef enum logic {
    EMPTY,
    SEND
  } state_t;

  state_t                               state_q;
  state_t                               state_d;
  logic [R-1:0][OUT_DAT_BITS-1:0]       word_q;
  logic                                 sop_q;
  logic                                 eop_q;
  logic                                 err_q;
  logic [CTL_BITS-1:0]                  ctl_q;
  logic [K_BITS-1:0]                    k_q;
  logic [K_BITS-1:0]                    last_k_q;
  logic [OUT_MOD_BITS-1:0]              last_mod_q;

  int                                   in_m;
  logic [K_BITS-1:0]                    in_last_k;
  logic [OUT_MOD_BITS-1:0]              in_last_mod;
  logic                                 send;
  logic                                 last_beat;
  logic                                 in_rdy;
  logic                                 accept;
  logic                                 beat_fire;

  assign send      = (state_q == SEND);
  assign last_beat = (k_q == last_k_q);
  assign beat_fire = send && o_axi.rdy;

  // Ready while idle, or when the final beat of the held word leaves this cycle
  // so the next word loads with no bubble. Forced low while reset is asserted.
  assign in_rdy = i_rst_n && (!send || (last_beat && o_axi.rdy));
  assign accept = i_axi.val && in_rdy;

  // Beat count and last-beat mod are resolved once at capture, not per beat.
  always_comb begin
    in_m        = (i_axi.mod == '0) ? IN_DAT_BYTS : int'(i_axi.mod);
    in_last_k   = K_BITS'(R - 1);
    in_last_mod = '0;
    if (i_axi.eop) begin
      in_last_k   = K_BITS'(width_down_beats(in_m, OUT_DAT_BYTS) - 1);
      in_last_mod = OUT_MOD_BITS'(width_down_last_mod(in_m, OUT_DAT_BYTS));
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = SEND;
      SEND:    if (beat_fire && last_beat && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      word_q     <= '0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      err_q      <= 1'b0;
      ctl_q      <= '0;
      k_q        <= '0;
      last_k_q   <= '0;
      last_mod_q <= '0;
    end else if (accept) begin
      word_q     <= i_axi.dat;
      sop_q      <= i_axi.sop;
      eop_q      <= i_axi.eop;
      err_q      <= i_axi.err;
      ctl_q      <= i_axi.ctl;
      k_q        <= '0;
      last_k_q   <= in_last_k;
      last_mod_q <= in_last_mod;
    end else if (beat_fire && !last_beat) begin
      k_q <= k_q + K_BITS'(1);
    end
  end

  // Fields are gated with send so an idle link shows all zeros.
  assign i_axi.rdy = in_rdy;
  assign o_axi.val = send;
  assign o_axi.dat = send ? word_q[k_q] : '0;
  assign o_axi.ctl = send ? ctl_q : '0;
  assign o_axi.sop = send && sop_q && (k_q == '0);
  assign o_axi.eop = send && eop_q && last_beat;
  assign o_axi.err = send && eop_q && last_beat && err_q;
  assign o_axi.mod = (send && eop_q && last_beat) ? last_mod_q : '0;

endmodule

// File: tb/tb_axi_stream_width_down.sv
// tb/tb_axi_stream_width_down.sv - randomized self-checking bench for axi_stream_width_down
module tb_axi_stream_width_down;

  localparam int IN_BYTS   = 8;
  localparam int OUT_BYTS  = 2;
  localparam int OUT_BITS  = OUT_BYTS * 8;
  localparam int OUT_MOD_W = 1;

  typedef struct {
    logic [OUT_BITS-1:0]  dat;
    logic                 sop;
    logic                 eop;
    logic                 err;
    logic [OUT_MOD_W-1:0] mod;
    logic [7:0]           ctl;
    int                   nvalid;
    int                   cyc;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  if_axi_stream #(.DAT_BYTS(IN_BYTS),  .CTL_BYTS(1)) in_if  ();
  if_axi_stream #(.DAT_BYTS(OUT_BYTS), .CTL_BYTS(1)) out_if ();

  axi_stream_width_down #(
    .IN_DAT_BYTS (IN_BYTS),
    .OUT_DAT_BYTS(OUT_BYTS),
    .CTL_BYTS    (1)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_axi  (in_if),
    .o_axi  (out_if)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         bp       = 0;
  beat_t      exp_q   [$];
  beat_t      rx_log  [$];
  int         acc_cyc [$];
  logic [7:0] tx_bytes  [$];
  logic [7:0] exp_bytes [$];
  int         exp_lens  [$];
  logic [7:0] rx_bytes  [$];
  int         rx_lens   [$];
  int         rx_cur    = 0;
  logic [15:0] t1_exp [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: an accepted word becomes ceil(valid_bytes/OUT_BYTS) beats in byte order.
  task automatic model_word(input logic [63:0] w, input logic sop, input logic eop,
                            input logic [2:0] mod, input logic err, input logic [7:0] ctl);
    int    nbytes;
    int    nbeats;
    int    valid;
    beat_t b;
    nbytes = (eop && mod != 0) ? int'(mod) : IN_BYTS;
    nbeats = (nbytes + OUT_BYTS - 1) / OUT_BYTS;
    for (int i = 0; i < nbeats; i++) begin
      valid    = nbytes - i * OUT_BYTS;
      if (valid > OUT_BYTS) valid = OUT_BYTS;
      b.dat    = w[i*OUT_BITS +: OUT_BITS];
      b.sop    = sop && (i == 0);
      b.eop    = eop && (i == nbeats - 1);
      b.err    = err && b.eop;
      b.mod    = (b.eop && valid != OUT_BYTS) ? OUT_MOD_W'(valid) : '0;
      b.ctl    = ctl;
      b.nvalid = valid;
      b.cyc    = 0;
      exp_q.push_back(b);
    end
  endtask

  always @(negedge clk) begin
    beat_t      h;
    beat_t      lb;
    logic       exp_rdy;
    logic [15:0] msk;
    int         valid;
    #3;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      rx_cur = 0;
    end else begin
      exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && out_if.rdy);
      check("in_rdy", in_if.rdy, exp_rdy);
      check("out_val", out_if.val, exp_q.size() != 0);
      if (out_if.val && exp_q.size() != 0) begin
        h   = exp_q[0];
        msk = '0;
        for (int j = 0; j < h.nvalid; j++) msk[j*8 +: 8] = 8'hFF;
        check("out_dat", out_if.dat & msk, h.dat & msk);
        check("out_sop", out_if.sop, h.sop);
        check("out_eop", out_if.eop, h.eop);
        check("out_err", out_if.err, h.err);
        check("out_mod", out_if.mod, h.mod);
        check("out_ctl", out_if.ctl, h.ctl);
        if (out_if.rdy) begin
          void'(exp_q.pop_front());
          lb.dat = out_if.dat; lb.sop = out_if.sop; lb.eop = out_if.eop;
          lb.err = out_if.err; lb.mod = out_if.mod; lb.ctl = out_if.ctl;
          lb.nvalid = h.nvalid; lb.cyc = cyc;
          rx_log.push_back(lb);
          valid = (out_if.eop && out_if.mod != 0) ? int'(out_if.mod) : OUT_BYTS;
          for (int j = 0; j < valid; j++) rx_bytes.push_back(out_if.dat[j*8 +: 8]);
          rx_cur += valid;
          if (out_if.eop) begin
            rx_lens.push_back(rx_cur);
            rx_cur = 0;
          end
        end
      end
      if (in_if.val && in_if.rdy) begin
        model_word(in_if.dat, in_if.sop, in_if.eop, in_if.mod, in_if.err, in_if.ctl);
        acc_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    out_if.rdy = 1'b0;
    forever begin
      @(negedge clk);
      out_if.rdy = ($urandom_range(0, 99) >= bp);
    end
  end

  task automatic put_word(input logic [63:0] w, input logic sop, input logic eop,
                          input logic [2:0] mod, input logic err, input logic [7:0] ctl);
    int   waited;
    logic took;
    in_if.dat = w; in_if.sop = sop; in_if.eop = eop;
    in_if.mod = mod; in_if.err = err; in_if.ctl = ctl;
    in_if.val = 1'b1;
    waited = 0;
    took   = 1'b0;
    while (!took && waited < 500) begin
      #3;
      took = in_if.rdy;
      @(negedge clk);
      waited++;
    end
    check("put_word_accepted", took, 1'b1);
  endtask

  task automatic put_stream(input logic err_last, input logic [7:0] ctl);
    int          len;
    int          nw;
    logic [63:0] w;
    logic [2:0]  mod;
    logic        last;
    len = tx_bytes.size();
    nw  = (len + IN_BYTS - 1) / IN_BYTS;
    for (int wi = 0; wi < nw; wi++) begin
      for (int b = 0; b < IN_BYTS; b++) begin
        if (wi * IN_BYTS + b < len) w[b*8 +: 8] = tx_bytes[wi*IN_BYTS + b];
        else                        w[b*8 +: 8] = 8'($urandom);
      end
      last = (wi == nw - 1);
      mod  = last ? 3'(len % IN_BYTS) : 3'd0;
      put_word(w, wi == 0, last, mod, last ? err_last : 1'($urandom_range(0, 1)), ctl);
    end
    in_if.val = 1'b0;
    foreach (tx_bytes[i]) exp_bytes.push_back(tx_bytes[i]);
    exp_lens.push_back(len);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_if.val) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("drained", exp_q.size(), 0);
  endtask

  task automatic check_rx();
    check("rx_pkt_count", rx_lens.size(), exp_lens.size());
    for (int i = 0; i < exp_lens.size() && i < rx_lens.size(); i++)
      check("rx_pkt_len", rx_lens[i], exp_lens[i]);
    check("rx_byte_count", rx_bytes.size(), exp_bytes.size());
    for (int i = 0; i < exp_bytes.size() && i < rx_bytes.size(); i++)
      check("rx_byte", rx_bytes[i], exp_bytes[i]);
    exp_lens.delete(); exp_bytes.delete(); rx_lens.delete(); rx_bytes.delete();
  endtask

  task automatic start_test();
    rx_log.delete();
    acc_cyc.delete();
    tx_bytes.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    t1_exp[0] = 16'h0100; t1_exp[1] = 16'h0302; t1_exp[2] = 16'h0504; t1_exp[3] = 16'h0706;
    rst_n = 1'b1;
    in_if.val = 1'b0; in_if.sop = 1'b0; in_if.eop = 1'b0; in_if.err = 1'b0;
    in_if.dat = '0;   in_if.mod = '0;   in_if.ctl = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_val", out_if.val, 0);
    check("rst_sop", out_if.sop, 0);
    check("rst_eop", out_if.eop, 0);
    check("rst_err", out_if.err, 0);
    check("rst_dat", out_if.dat, 0);
    check("rst_mod", out_if.mod, 0);
    check("rst_ctl", out_if.ctl, 0);
    check("rst_in_rdy", in_if.rdy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check("release_in_rdy", in_if.rdy, 1);
    @(negedge clk);

    // Single full word, one packet
    bp = 0;
    start_test();
    for (int i = 0; i < 8; i++) tx_bytes.push_back(8'(i));
    put_stream(1'b0, 8'h00);
    wait_drain();
    check("t1_beats", rx_log.size(), 4);
    for (int i = 0; i < rx_log.size() && i < 4; i++) begin
      check("t1_dat", rx_log[i].dat, t1_exp[i]);
      check("t1_sop", rx_log[i].sop, i == 0);
      check("t1_eop", rx_log[i].eop, i == 3);
      check("t1_mod", rx_log[i].mod, 0);
    end
    if (rx_log.size() > 0 && acc_cyc.size() > 0)
      check("t1_latency", rx_log[0].cyc - acc_cyc[0], 1);
    check_rx();

    // 13-byte packet, sink always ready then 50% backpressure
    for (int pass = 0; pass < 2; pass++) begin
      bp = (pass == 0) ? 0 : 50;
      @(negedge clk);
      start_test();
      for (int i = 0; i < 13; i++) tx_bytes.push_back(8'(i));
      put_stream(1'b0, 8'h11);
      wait_drain();
      check("t2_beats", rx_log.size(), 7);
      if (rx_log.size() == 7) begin
        check("t2_last_byte", rx_log[6].dat[7:0], 8'h0C);
        check("t2_last_eop", rx_log[6].eop, 1);
        check("t2_last_mod", rx_log[6].mod, 1);
      end
      if (rx_lens.size() > 0) check("t2_len", rx_lens[0], 13);
      check_rx();
    end

    // Three back-to-back 16-byte packets with no output gaps
    bp = 0;
    @(negedge clk);
    start_test();
    for (int p = 0; p < 3; p++) begin
      tx_bytes.delete();
      for (int i = 0; i < 16; i++) tx_bytes.push_back(8'($urandom));
      put_stream(1'b0, 8'h22);
    end
    wait_drain();
    check("t4_beats", rx_log.size(), 24);
    for (int i = 1; i < rx_log.size(); i++)
      check("t4_no_gap", rx_log[i].cyc - rx_log[i-1].cyc, 1);
    check("t4_words", acc_cyc.size(), 6);
    for (int i = 1; i < acc_cyc.size(); i++)
      check("t4_rdy_period", acc_cyc[i] - acc_cyc[i-1], 4);
    check_rx();

    // err on the eop word (mod=3), ctl on every beat
    start_test();
    for (int i = 0; i < 11; i++) tx_bytes.push_back(8'(8'h40 + i));
    put_stream(1'b1, 8'hA5);
    wait_drain();
    check("t5_beats", rx_log.size(), 6);
    for (int i = 0; i < rx_log.size(); i++) begin
      check("t5_err", rx_log[i].err, i == 5);
      check("t5_ctl", rx_log[i].ctl, 8'hA5);
    end
    if (rx_log.size() == 6) begin
      check("t5_last_mod", rx_log[5].mod, 1);
      check("t5_last_eop", rx_log[5].eop, 1);
      check("t5_last_byte", rx_log[5].dat[7:0], 8'h4A);
    end
    check_rx();

    // Reset in the middle of a word
    start_test();
    for (int i = 0; i < 8; i++) tx_bytes.push_back(8'(8'h80 + i));
    put_stream(1'b0, 8'h5A);
    n = 0;
    while (rx_log.size() < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    #1 check("t6_val_before_rst", out_if.val, 1);
    rst_n = 1'b0;
    #1;
    check("t6_val_in_rst", out_if.val, 0);
    check("t6_dat_in_rst", out_if.dat, 0);
    check("t6_in_rdy_in_rst", in_if.rdy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("t6_in_rdy_release", in_if.rdy, 1);
    exp_lens.delete(); exp_bytes.delete(); rx_lens.delete(); rx_bytes.delete();
    @(negedge clk);
    start_test();
    for (int i = 0; i < 4; i++) tx_bytes.push_back(8'(8'hB0 + i));
    put_stream(1'b0, 8'h3C);
    wait_drain();
    check("t6_beats", rx_log.size(), 2);
    if (rx_log.size() > 0) begin
      check("t6_first_sop", rx_log[0].sop, 1);
      check("t6_first_dat", rx_log[0].dat, 16'hB1B0);
    end
    check_rx();

    // Randomized packets under varying backpressure
    for (int grp = 0; grp < 4; grp++) begin
      bp = (grp == 0) ? 0 : (grp == 1) ? 30 : (grp == 2) ? 70 : 50;
      for (int p = 0; p < 10; p++) begin
        tx_bytes.delete();
        n = $urandom_range(1, 40);
        for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom));
        put_stream(1'($urandom_range(0, 1)), 8'($urandom));
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_drain();
      check_rx();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
